huff_stream_decoder: RTL and testbench
======================================

// Module: huff_stream_decoder
// PURPOSE
//  Receiver side of the Huffman code link: loads an 8-entry code table (len+code per symbol), then consumes
//  a serial code bitstream and emits one decoded symbol index per completed codeword. Sits downstream of
//  the Huffman encoder/serializer; flags invalid codewords and an optional non-prefix-free table.
// PARAMETERS
//  NSYM    8  number of symbols / table entries (index width SW=$clog2(NSYM)=3)
//  MAXLEN  7  maximum codeword length in bits (length field width 3)
// PORTS
//  clk        in   1  clock, rising edge
//  rst_n      in   1  reset, asynchronous, active-low
//  tbl_valid  in   1  table entry strobe; entries arrive in symbol order 0..NSYM-1
//  tbl_len    in   3  codeword length of current symbol; 0 = symbol unused
//  tbl_code   in   7  codeword, right-aligned; bit [len-1] is first on the wire
//  bit_valid  in   1  stream bit strobe
//  bit_in     in   1  stream bit
//  bit_last   in   1  qualifies bit_valid: final bit of the stream
//  bit_ready  out  1  high when bits are accepted (state DEC)
//  out_valid  out  1  one-cycle pulse: out_sym valid
//  out_sym    out  3  decoded symbol index (0 when out_valid low)
//  dec_err    out  1  one-cycle pulse: invalid codeword / truncated stream
//  tbl_err    out  1  one-cycle pulse: loaded table rejected (tied 0 without HSD_PREFIX_CHK_EN)
//  done       out  1  one-cycle pulse: stream finished, block back in IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, table/accumulator/counters cleared. Reset mid-operation drops table.
//  - FSM: IDLE -> LOAD on first tbl_valid (that entry is captured as symbol 0). LOAD: entry counter advances
//    only on tbl_valid (gaps allowed); after entry NSYM-1 -> CHK (macro on) or DEC (macro off).
//    DEC: bit_ready=1. After bit_last is processed -> IDLE; done pulses the cycle after the last bit.
//  - tbl_valid outside IDLE/LOAD ignored; bit_valid outside DEC ignored (bit_ready=0).
//  - Decode: accumulator acc[6:0], length cnt[2:0]. Accepted bit: acc_n={acc,bit_in}, cnt_n=cnt+1.
//    Match if some entry has len==cnt_n and code==acc_n[len-1:0]; on multiple matches lowest index wins.
//  - Match on accepted bit at cycle t: out_valid=1, out_sym=index at t+1; acc,cnt cleared same edge.
//  - No match and cnt_n==MAXLEN: dec_err pulse at t+1, acc/cnt cleared, decoding continues with next bit.
//  - bit_last with no match and cnt_n<MAXLEN (truncated codeword): dec_err at t+1 with done at t+1.
//  - bit_last completing a codeword: out_valid and done both at t+1. Throughput 1 bit/cycle, no stalls.
//  - Length 0 entries never match; all-zero table -> every MAXLEN bits gives dec_err.
//  - Width rules: compare only the low len bits of tbl_code; upper bits of tbl_code ignored.
// CONFIGURATION
//  HSD_PREFIX_CHK_EN defined: state CHK scans all pairs (i<j) with both len!=0, one pair per cycle
//    (28 cycles for NSYM=8). Pair fails if shorter code equals the top bits of the longer (equal len: equal
//    codes). Any failure: tbl_err pulse on cycle after scan end, -> IDLE, table discarded. Pass -> DEC.
//  Not defined: no CHK state; LOAD -> DEC directly after last entry; tbl_err constant 0; lowest-index rule
//    resolves ambiguous tables.
// STRUCTURE
//  Shared package hsd_pkg: NSYM, MAXLEN, SW, LW, state enum {IDLE,LOAD,CHK,DEC}, entry typedef {len,code}.
//  One sub-module natural: hsd_match (combinational) - acc_n,cnt_n,table -> hit, sym (priority encoder).
//  Top holds FSM, table regs, accumulator, counters, output regs and the CHK pair iterator.
// TESTING
//  T1 table s0={1,0},s1={2,10},s2={3,110},s3={3,111},s4..7 len0; bits 0,1,0,1,1,1(last)
//     -> out_sym 0,1,3 one cycle after bits 1,3,6; done with the final out_valid.
//  T2 same table, bits 1,1 with bit_last on 2nd -> dec_err+done one cycle later, no out_valid.
//  T3 table with only s5={7,1010101}; stream 1111111 -> dec_err after 7th bit; then 1010101 -> out_sym 5.
//  T4 tbl_valid with 3 gap cycles mid-load and bit_valid during LOAD -> table intact, early bits ignored,
//     bit_ready rises only after entry 7 (+28 cycles with macro).
//  T5 (macro on) s0={1,1},s1={2,10} -> tbl_err pulse, back to IDLE, bit_ready stays 0; (macro off) accepted,
//     bit 1 decodes as s0.
//  T6 rst_n low mid-stream after 2 bits of a 3-bit code -> all outputs 0, IDLE; reload+restream decodes cleanly.

Source files
------------

// File: rtl/hsd_pkg.sv
// Shared types and helpers for the Huffman stream decoder.
// Build option: HSD_PREFIX_CHK_EN enables the table prefix-free scan.
package hsd_pkg;

  localparam int NSYM   = 8;
  localparam int MAXLEN = 7;
  localparam int SW     = $clog2(NSYM);
  localparam int LW     = 3;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CHK,
    DEC
  } state_t;

  typedef struct packed {
    logic [LW-1:0]     len;
    logic [MAXLEN-1:0] code;
  } entry_t;

  function automatic logic [MAXLEN-1:0] len_mask(
    input logic [LW-1:0] l
  );
    logic [MAXLEN:0] one;
    one = 1;
    return MAXLEN'((one << l) - 1'b1);
  endfunction

  // Shorter code compared against the first bits on the wire of the longer.
  function automatic logic prefix_clash(
    input entry_t a,
    input entry_t b
  );
    logic [LW-1:0]     ls;
    logic [MAXLEN-1:0] sa;
    logic [MAXLEN-1:0] sb;
    if (a.len <= b.len) begin
      ls = a.len;
      sa = a.code;
      sb = b.code >> (b.len - a.len);
    end else begin
      ls = b.len;
      sa = a.code >> (a.len - b.len);
      sb = b.code;
    end
    return ((sa ^ sb) & len_mask(ls)) == '0;
  endfunction

endpackage

// File: rtl/hsd_if.sv
// Table load, bit stream and result signals of the decoder.
// Build option: HSD_PREFIX_CHK_EN (drives tbl_err).
interface hsd_if;
  import hsd_pkg::*;

  logic              tbl_valid;
  logic [LW-1:0]     tbl_len;
  logic [MAXLEN-1:0] tbl_code;
  logic              bit_valid;
  logic              bit_in;
  logic              bit_last;
  logic              bit_ready;
  logic              out_valid;
  logic [SW-1:0]     out_sym;
  logic              dec_err;
  logic              tbl_err;
  logic              done;

  modport master (
    output tbl_valid, tbl_len, tbl_code,
    output bit_valid, bit_in, bit_last,
    input  bit_ready, out_valid, out_sym,
    input  dec_err, tbl_err, done
  );

  modport slave (
    input  tbl_valid, tbl_len, tbl_code,
    input  bit_valid, bit_in, bit_last,
    output bit_ready, out_valid, out_sym,
    output dec_err, tbl_err, done
  );

endinterface

// File: rtl/hsd_match.sv
// Codeword lookup: finds the table entry matching the accumulated bits.
// Build option: HSD_PREFIX_CHK_EN (not used here).
module hsd_match
  import hsd_pkg::*;
(
  input  logic [MAXLEN-1:0] acc_n,
  input  logic [LW-1:0]     cnt_n,
  input  entry_t            tbl [NSYM],
  output logic              hit,
  output logic [SW-1:0]     sym
);

  // Scan high to low so the lowest matching index is left in sym.
  always_comb begin
    hit = 1'b0;
    sym = '0;
    for (int i = NSYM - 1; i >= 0; i--) begin
      if (tbl[i].len != '0 &&
          tbl[i].len == cnt_n &&
          ((tbl[i].code ^ acc_n) &
           len_mask(tbl[i].len)) == '0) begin
        hit = 1'b1;
        sym = SW'(i);
      end
    end
  end

endmodule

// File: rtl/huff_stream_decoder.sv
// Huffman bitstream decoder: table load, optional prefix scan, decode.
// Build option: HSD_PREFIX_CHK_EN adds the CHK table scan and tbl_err.
module huff_stream_decoder
  import hsd_pkg::*;
(
  input logic  clk,
  input logic  rst_n,
  hsd_if.slave bus
);

  state_t            state_q, state_d;
  entry_t            tbl_q [NSYM];
  logic [SW-1:0]     ent_q, ent_d;
  logic [MAXLEN-1:0] acc_q, acc_d, acc_n;
  logic [LW-1:0]     cnt_q, cnt_d, cnt_n;
  logic              hit;
  logic [SW-1:0]     hit_sym;
  logic              ov_q, ov_d;
  logic [SW-1:0]     sym_q, sym_d;
  logic              de_q, de_d;
  logic              dn_q, dn_d;
  logic              tbl_we;
  logic              tbl_clr;

`ifdef HSD_PREFIX_CHK_EN
  logic [SW-1:0]     pi_q, pi_d;
  logic [SW-1:0]     pj_q, pj_d;
  logic              fail_q, fail_d;
  logic              te_q, te_d;
  logic              pair_bad;
  logic              last_pair;

  assign pair_bad = tbl_q[pi_q].len != '0 &&
                    tbl_q[pj_q].len != '0 &&
                    prefix_clash(tbl_q[pi_q], tbl_q[pj_q]);
  assign last_pair = pi_q == SW'(NSYM - 2) &&
                     pj_q == SW'(NSYM - 1);
`endif

  assign acc_n = {acc_q[MAXLEN-2:0], bus.bit_in};
  assign cnt_n = cnt_q + 1'b1;

  hsd_match u_match (
    .acc_n (acc_n),
    .cnt_n (cnt_n),
    .tbl   (tbl_q),
    .hit   (hit),
    .sym   (hit_sym)
  );

  always_comb begin
    state_d = state_q;
    ent_d   = ent_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ov_d    = 1'b0;
    sym_d   = '0;
    de_d    = 1'b0;
    dn_d    = 1'b0;
    tbl_we  = 1'b0;
    tbl_clr = 1'b0;
`ifdef HSD_PREFIX_CHK_EN
    pi_d    = pi_q;
    pj_d    = pj_q;
    fail_d  = fail_q;
    te_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.tbl_valid) begin
          tbl_we  = 1'b1;
          ent_d   = ent_q + 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (bus.tbl_valid) begin
          tbl_we = 1'b1;
          ent_d  = ent_q + 1'b1;
          if (ent_q == SW'(NSYM - 1)) begin
`ifdef HSD_PREFIX_CHK_EN
            state_d = CHK;
`else
            state_d = DEC;
`endif
          end
        end
      end
      CHK: begin
`ifdef HSD_PREFIX_CHK_EN
        if (last_pair) begin
          pi_d   = '0;
          pj_d   = SW'(1);
          fail_d = 1'b0;
          if (fail_q || pair_bad) begin
            te_d    = 1'b1;
            tbl_clr = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = DEC;
          end
        end else begin
          fail_d = fail_q | pair_bad;
          if (pj_q == SW'(NSYM - 1)) begin
            pi_d = pi_q + 1'b1;
            pj_d = pi_q + SW'(2);
          end else begin
            pj_d = pj_q + 1'b1;
          end
        end
`else
        state_d = IDLE;
`endif
      end
      DEC: begin
        if (bus.bit_valid) begin
          acc_d = acc_n;
          cnt_d = cnt_n;
          if (hit) begin
            ov_d  = 1'b1;
            sym_d = hit_sym;
            acc_d = '0;
            cnt_d = '0;
          end else if (cnt_n == LW'(MAXLEN) ||
                       bus.bit_last) begin
            de_d  = 1'b1;
            acc_d = '0;
            cnt_d = '0;
          end
          if (bus.bit_last) begin
            dn_d    = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ent_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      sym_q   <= '0;
      de_q    <= 1'b0;
      dn_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ent_q   <= ent_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      sym_q   <= sym_d;
      de_q    <= de_d;
      dn_q    <= dn_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSYM; i++) tbl_q[i] <= '0;
    end else if (tbl_clr) begin
      for (int i = 0; i < NSYM; i++) tbl_q[i] <= '0;
    end else if (tbl_we) begin
      tbl_q[ent_q] <= '{len: bus.tbl_len,
                        code: bus.tbl_code};
    end
  end

`ifdef HSD_PREFIX_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pi_q   <= '0;
      pj_q   <= SW'(1);
      fail_q <= 1'b0;
      te_q   <= 1'b0;
    end else begin
      pi_q   <= pi_d;
      pj_q   <= pj_d;
      fail_q <= fail_d;
      te_q   <= te_d;
    end
  end

  assign bus.tbl_err = te_q;
`else
  assign bus.tbl_err = 1'b0;
`endif

  assign bus.bit_ready = state_q == DEC;
  assign bus.out_valid = ov_q;
  assign bus.out_sym   = sym_q;
  assign bus.dec_err   = de_q;
  assign bus.done      = dn_q;

endmodule

// File: tb/tb_huff_stream_decoder.sv
// Self-checking bench for huff_stream_decoder with a codeword-level model.
// Build option: HSD_PREFIX_CHK_EN selects the CHK expectations.
module tb_huff_stream_decoder;
  import hsd_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hsd_if bus ();

  huff_stream_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int passed = 0;
  int nfail = 0;
  int tl [NSYM];
  int tc [NSYM];
  bit bq [$];
  int got [$];
  bit ok;
  logic [31:0] v;

  // Packed view: {bit_ready, tbl_err, done, dec_err, out_valid, out_sym}
  function automatic logic [7:0] outs();
    return {bus.bit_ready, bus.tbl_err, bus.done,
            bus.dec_err, bus.out_valid, bus.out_sym};
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    bus.tbl_valid = 1'b0;
    bus.tbl_len   = '0;
    bus.tbl_code  = '0;
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
    bus.bit_last  = 1'b0;
  endtask

  task automatic push_bits(input int val, input int n);
    for (int k = n - 1; k >= 0; k--)
      bq.push_back(1'((val >> k) & 1));
  endtask

  // Prefix-free test on the wire-order bit strings of the table.
  function automatic bit clash_model();
    for (int i = 0; i < NSYM; i++)
      for (int j = i + 1; j < NSYM; j++) begin
        int s;
        bit same;
        if (tl[i] == 0 || tl[j] == 0) continue;
        s = (tl[i] < tl[j]) ? tl[i] : tl[j];
        same = 1'b1;
        for (int k = 0; k < s; k++)
          if (((tc[i] >> (tl[i] - 1 - k)) & 1) !=
              ((tc[j] >> (tl[j] - 1 - k)) & 1))
            same = 1'b0;
        if (same) return 1'b1;
      end
    return 1'b0;
  endfunction

  task automatic load_table(input int gap_at,
                            input int gap_n,
                            output bit okay);
    bit bad;
    bad = clash_model();
    for (int i = 0; i < NSYM; i++) begin
      if (i == gap_at) begin
        repeat (gap_n) begin
          bus.tbl_valid = 1'b0;
          bus.bit_valid = 1'b1;
          bus.bit_in    = 1'($urandom);
          bus.bit_last  = 1'($urandom);
          tick();
          check("load_gap", outs(), 8'h00);
        end
      end
      bus.tbl_valid = 1'b1;
      bus.tbl_len   = 3'(tl[i]);
      bus.tbl_code  = 7'(tc[i]);
      bus.bit_valid = 1'($urandom);
      bus.bit_in    = 1'($urandom);
      bus.bit_last  = 1'($urandom);
      tick();
      if (i < NSYM - 1) check("load", outs(), 8'h00);
    end
    idle_in();
`ifdef HSD_PREFIX_CHK_EN
    check("chk_entry", outs(), 8'h00);
    for (int k = 1; k <= 28; k++) begin
      tick();
      if (k < 28) check("chk_scan", outs(), 8'h00);
      else check("chk_end", outs(),
                 bad ? 8'h40 : 8'h80);
    end
    okay = !bad;
`else
    check("load_end", outs(), 8'h80);
    okay = 1'b1;
`endif
  endtask

  // Model: grow the current codeword one bit at a time and
  // look it up among entries of exactly that length.
  task automatic send_stream;
    int macc;
    int mcnt;
    int n;
    macc = 0;
    mcnt = 0;
    n = bq.size();
    for (int idx = 0; idx < n; idx++) begin
      int hs;
      bit last;
      logic [7:0] exp;
      if ($urandom_range(0, 3) == 0) begin
        idle_in();
        bus.tbl_valid = 1'($urandom);
        tick();
        check("bubble", outs(), 8'h80);
      end
      last = (idx == n - 1);
      bus.bit_valid = 1'b1;
      bus.bit_in    = bq[idx];
      bus.bit_last  = last;
      bus.tbl_valid = 1'($urandom);
      bus.tbl_len   = 3'($urandom);
      bus.tbl_code  = 7'($urandom);
      macc = macc * 2 + int'(bq[idx]);
      mcnt++;
      hs = -1;
      for (int i = 0; i < NSYM; i++)
        if (hs < 0 && tl[i] == mcnt &&
            (tc[i] & ((1 << tl[i]) - 1)) == macc)
          hs = i;
      exp = 8'h00;
      if (hs >= 0) begin
        exp = 8'h08 | 8'(hs);
        macc = 0;
        mcnt = 0;
      end else if (mcnt == MAXLEN || last) begin
        exp = 8'h10;
        macc = 0;
        mcnt = 0;
      end
      exp |= last ? 8'h20 : 8'h80;
      tick();
      check("bit", outs(), exp);
      if (bus.out_valid) got.push_back(int'(bus.out_sym));
    end
    idle_in();
    tick();
    check("post", outs(), 8'h00);
    bq.delete();
  endtask

  task automatic t1_table;
    tl = '{1, 2, 3, 3, 0, 0, 0, 0};
    tc = '{0, 2, 6, 7, 0, 0, 0, 0};
  endtask

  task automatic check_t1_syms(input string tag);
    v = (got.size() == 3) ?
        {23'd0, got[0][2:0], got[1][2:0], got[2][2:0]} :
        32'hffff;
    check(tag, v, {23'd0, 3'd0, 3'd1, 3'd3});
  endtask

  initial begin
    idle_in();
    repeat (2) @(negedge clk);
    check("reset", outs(), 8'h00);
    rst_n = 1'b1;
    tick();
    check("idle", outs(), 8'h00);

    // T1
    t1_table();
    load_table(-1, 0, ok);
    got.delete();
    push_bits(6'b010111, 6);
    send_stream();
    check_t1_syms("t1_syms");

    // T2
    load_table(-1, 0, ok);
    got.delete();
    push_bits(2'b11, 2);
    send_stream();
    check("t2_nosym", got.size(), 0);

    // T3
    tl = '{0, 0, 0, 0, 0, 7, 0, 0};
    tc = '{0, 0, 0, 0, 0, 7'b1010101, 0, 0};
    load_table(-1, 0, ok);
    got.delete();
    push_bits(7'b1111111, 7);
    push_bits(7'b1010101, 7);
    send_stream();
    v = (got.size() == 1) ? got[0] : 32'hffff;
    check("t3_sym", v, 5);

    // T4
    t1_table();
    load_table(3, 3, ok);
    got.delete();
    push_bits(6'b010111, 6);
    send_stream();
    check_t1_syms("t4_syms");

    // T5
    tl = '{1, 2, 0, 0, 0, 0, 0, 0};
    tc = '{1, 2, 0, 0, 0, 0, 0, 0};
    load_table(-1, 0, ok);
`ifdef HSD_PREFIX_CHK_EN
    bus.bit_valid = 1'b1;
    bus.bit_in    = 1'b1;
    bus.bit_last  = 1'b1;
    tick();
    check("t5_rejected", outs(), 8'h00);
    idle_in();
    tick();
    check("t5_idle", outs(), 8'h00);
`else
    got.delete();
    push_bits(1, 1);
    send_stream();
    v = (got.size() == 1) ? got[0] : 32'hffff;
    check("t5_sym", v, 0);
`endif

    // T6
    t1_table();
    load_table(-1, 0, ok);
    bus.bit_valid = 1'b1;
    bus.bit_in    = 1'b1;
    tick();
    check("t6_bit1", outs(), 8'h80);
    tick();
    check("t6_bit2", outs(), 8'h80);
    idle_in();
    #2 rst_n = 1'b0;
    #1 check("t6_reset", outs(), 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t6_idle", outs(), 8'h00);
    load_table(-1, 0, ok);
    got.delete();
    push_bits(6'b010111, 6);
    send_stream();
    check_t1_syms("t6_syms");

    // Random tables and streams
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NSYM; i++) begin
        tl[i] = ($urandom_range(0, 2) == 0) ?
                0 : $urandom_range(1, 7);
        tc[i] = $urandom_range(0, 127);
      end
      if (r == 0) tl[0] = 0;
      load_table($urandom_range(0, 7),
                 $urandom_range(0, 3), ok);
      if (ok) begin
        for (int k = 0; k < 30; k++)
          bq.push_back(1'($urandom));
        send_stream();
      end else begin
        tick();
        check("rnd_rejected", outs(), 8'h00);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
